la_trg_seq: RTL and testbench

LA_TRG_SEQ -- requirements
Module: la_trg_seq

---
 rtl/la_pkg.sv | 18 +
 rtl/la_trg_cmp.sv | 28 ++
 rtl/la_trg_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_la_trg_seq.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// la_pkg: shared trigger sequencer types.
// State encoding here is the sts_sta status encoding.
package la_pkg;

   localparam int STA_W = 2;

   typedef enum logic [STA_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRED = 2'd2
   } la_sta_e;

   // Stage index width, never below one bit
   function automatic int stg_w(input int sn);
      return (sn > 1) ? $clog2(sn) : 1;
   endfunction

endpackage

// File: rtl/la_trg_cmp.sv
// la_trg_cmp: one trigger stage, level compare plus optional edge detect.
// An edge can only be seen when the previous sample is valid.
module la_trg_cmp
   import la_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [DW-1:0] d_i,
   input  logic [DW-1:0] dp_i,
   input  logic          dpv_i,
   input  logic [DW-1:0] msk_i,
   input  logic [DW-1:0] val_i,
   input  logic [DW-1:0] pos_i,
   input  logic [DW-1:0] neg_i,
   output logic          hit_o
);

   logic lvl;
   logic sel;
   logic edg;

   assign lvl = ((d_i ^ val_i) & msk_i) == '0;
   assign sel = |(pos_i | neg_i);
   assign edg = dpv_i &
                |((d_i & ~dp_i & pos_i) | (~d_i & dp_i & neg_i));
   assign hit_o = lvl & (~sel | edg);

endmodule

// File: rtl/la_trg_seq.sv
// la_trg_seq: multi-stage trigger sequencer on a registered sample stream.
// Inter-stage timeout is built only when LA_TRG_SEQ_TMO_EN is defined.
module la_trg_seq
   import la_pkg::*;
#(
   parameter int DW = 16,
   parameter int SN = 4,
   parameter int CW = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    ctl_rst,
   input  logic                    ctl_arm,
   input  logic [$clog2(SN):0]     cfg_num,
   input  logic                    cfg_rpt,
   input  logic [SN*DW-1:0]        cfg_msk,
   input  logic [SN*DW-1:0]        cfg_val,
   input  logic [SN*DW-1:0]        cfg_pos,
   input  logic [SN*DW-1:0]        cfg_neg,
   input  logic [SN*CW-1:0]        cfg_cnt,
   input  logic [CW-1:0]           cfg_tmo,
   input  logic [DW-1:0]           sti_tdata,
   input  logic                    sti_tvalid,
   output logic                    sti_tready,
   output logic [DW-1:0]           sto_tdata,
   output logic                    sto_tvalid,
   input  logic                    sto_tready,
   output logic                    sto_ttrg,
   output logic [STA_W-1:0]        sts_sta,
   output logic [stg_w(SN)-1:0]    sts_stg,
   output logic                    trg_out
);

   localparam int SW = stg_w(SN);

   la_sta_e        sta_q, sta_d;
   logic [SW-1:0]  stg_q, stg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]  dp_q;
   logic           dpv_q;
   logic [DW-1:0]  od_q;
   logic           ov_q;
   logic           ot_q;

   logic           xfer;
   logic           fire;
   logic [SN-1:0]  hit;
   logic           hit_cur;
   logic [CW-1:0]  req_cur;
   logic [CW-1:0]  req_eff;
   logic [CW-1:0]  cnt_inc;
   logic           reach;
   logic           is_last;
   logic [SW-1:0]  last;

   assign sti_tready = ~ov_q | sto_tready;
   assign xfer       = sti_tvalid & sti_tready;

   for (genvar g = 0; g < SN; g++) begin : g_cmp
      la_trg_cmp #(.DW(DW)) u_cmp (
         .d_i   (sti_tdata),
         .dp_i  (dp_q),
         .dpv_i (dpv_q),
         .msk_i (cfg_msk[g*DW +: DW]),
         .val_i (cfg_val[g*DW +: DW]),
         .pos_i (cfg_pos[g*DW +: DW]),
         .neg_i (cfg_neg[g*DW +: DW]),
         .hit_o (hit[g])
      );
   end

   // Clamp the active stage count into 1..SN
   always_comb begin
      if (cfg_num == '0)
         last = '0;
      else if (int'(cfg_num) > SN)
         last = SW'(SN - 1);
      else
         last = SW'(cfg_num - 1'b1);
   end

   always_comb begin
      hit_cur = 1'b0;
      req_cur = '0;
      for (int i = 0; i < SN; i++) begin
         if (stg_q == SW'(i)) begin
            hit_cur = hit[i];
            req_cur = cfg_cnt[i*CW +: CW];
         end
      end
   end

   assign req_eff = (req_cur == '0) ? CW'(1) : req_cur;
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   assign reach   = cnt_inc >= req_eff;
   assign is_last = stg_q >= last;

`ifdef LA_TRG_SEQ_TMO_EN
   logic [CW-1:0] tmr_q, tmr_d;
   logic [CW-1:0] tmr_inc;
   logic          tmo_on;

   assign tmr_inc = (&tmr_q) ? tmr_q : tmr_q + 1'b1;
   assign tmo_on  = (stg_q != '0) && (cfg_tmo != '0);
`else
   logic unused_tmo;
   assign unused_tmo = ^cfg_tmo;
`endif

   always_comb begin
      sta_d = sta_q;
      stg_d = stg_q;
      cnt_d = cnt_q;
      fire  = 1'b0;
`ifdef LA_TRG_SEQ_TMO_EN
      tmr_d = '0;
`endif
      unique case (sta_q)
         ST_IDLE: ;
         ST_ARMED: begin
`ifdef LA_TRG_SEQ_TMO_EN
            if (tmo_on)
               tmr_d = tmr_inc;
`endif
            if (xfer && hit_cur) begin
               if (reach) begin
                  cnt_d = '0;
`ifdef LA_TRG_SEQ_TMO_EN
                  tmr_d = '0;
`endif
                  if (is_last) begin
                     sta_d = ST_FIRED;
                     fire  = 1'b1;
                  end else begin
                     stg_d = stg_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
`ifdef LA_TRG_SEQ_TMO_EN
            else if (tmo_on && tmr_inc >= cfg_tmo) begin
               stg_d = '0;
               cnt_d = '0;
               tmr_d = '0;
            end
`endif
         end
         ST_FIRED: begin
            sta_d = cfg_rpt ? ST_ARMED : ST_IDLE;
            stg_d = '0;
            cnt_d = '0;
         end
         default: sta_d = ST_IDLE;
      endcase
      if (ctl_arm) begin
         sta_d = ST_ARMED;
         stg_d = '0;
         cnt_d = '0;
         fire  = 1'b0;
`ifdef LA_TRG_SEQ_TMO_EN
         tmr_d = '0;
`endif
      end
      if (ctl_rst) begin
         sta_d = ST_IDLE;
         stg_d = '0;
         cnt_d = '0;
         fire  = 1'b0;
`ifdef LA_TRG_SEQ_TMO_EN
         tmr_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sta_q <= ST_IDLE;
         stg_q <= '0;
         cnt_q <= '0;
`ifdef LA_TRG_SEQ_TMO_EN
         tmr_q <= '0;
`endif
      end else begin
         sta_q <= sta_d;
         stg_q <= stg_d;
         cnt_q <= cnt_d;
`ifdef LA_TRG_SEQ_TMO_EN
         tmr_q <= tmr_d;
`endif
      end
   end

   // Output register and previous-sample history for edge detect
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         od_q  <= '0;
         ov_q  <= 1'b0;
         ot_q  <= 1'b0;
         dp_q  <= '0;
         dpv_q <= 1'b0;
      end else begin
         if (ctl_rst) begin
            od_q <= '0;
            ov_q <= 1'b0;
            ot_q <= 1'b0;
         end else if (xfer) begin
            od_q <= sti_tdata;
            ov_q <= 1'b1;
            ot_q <= fire;
         end else if (sto_tready) begin
            ov_q <= 1'b0;
            ot_q <= 1'b0;
         end
         if (ctl_rst) begin
            dp_q  <= '0;
            dpv_q <= 1'b0;
         end else if (ctl_arm) begin
            dpv_q <= 1'b0;
         end else if (xfer) begin
            dp_q  <= sti_tdata;
            dpv_q <= 1'b1;
         end
      end
   end

   assign sto_tdata  = od_q;
   assign sto_tvalid = ov_q;
   assign sto_ttrg   = ot_q;
   assign sts_sta    = sta_q;
   assign sts_stg    = stg_q;
   assign trg_out    = (sta_q == ST_FIRED);

endmodule

// File: tb/tb_la_trg_seq.sv
// tb_la_trg_seq: directed and random stimulus against a stream/trigger model.
// Timeout expectations follow LA_TRG_SEQ_TMO_EN.
module tb_la_trg_seq;

   localparam int DW = 16;
   localparam int SN = 2;
   localparam int CW = 16;
   localparam int NW = $clog2(SN) + 1;
   localparam int SW = (SN > 1) ? $clog2(SN) : 1;
`ifdef LA_TRG_SEQ_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic             clk;
   logic             rstn;
   logic             ctl_rst;
   logic             ctl_arm;
   logic [NW-1:0]    cfg_num;
   logic             cfg_rpt;
   logic [SN*DW-1:0] cfg_msk;
   logic [SN*DW-1:0] cfg_val;
   logic [SN*DW-1:0] cfg_pos;
   logic [SN*DW-1:0] cfg_neg;
   logic [SN*CW-1:0] cfg_cnt;
   logic [CW-1:0]    cfg_tmo;
   logic [DW-1:0]    sti_tdata;
   logic             sti_tvalid;
   logic             sti_tready;
   logic [DW-1:0]    sto_tdata;
   logic             sto_tvalid;
   logic             sto_tready;
   logic             sto_ttrg;
   logic [1:0]       sts_sta;
   logic [SW-1:0]    sts_stg;
   logic             trg_out;

   la_trg_seq #(.DW(DW), .SN(SN), .CW(CW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ctl_rst    (ctl_rst),
      .ctl_arm    (ctl_arm),
      .cfg_num    (cfg_num),
      .cfg_rpt    (cfg_rpt),
      .cfg_msk    (cfg_msk),
      .cfg_val    (cfg_val),
      .cfg_pos    (cfg_pos),
      .cfg_neg    (cfg_neg),
      .cfg_cnt    (cfg_cnt),
      .cfg_tmo    (cfg_tmo),
      .sti_tdata  (sti_tdata),
      .sti_tvalid (sti_tvalid),
      .sti_tready (sti_tready),
      .sto_tdata  (sto_tdata),
      .sto_tvalid (sto_tvalid),
      .sto_tready (sto_tready),
      .sto_ttrg   (sto_ttrg),
      .sts_sta    (sts_sta),
      .sts_stg    (sts_stg),
      .trg_out    (trg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      bit            t;
   } smp_t;

   int checks = 0;
   int errors = 0;

   // Model: status, stage, occurrences, cycles spent in stage
   int            m_sta, m_stg, m_occ, m_el;
   logic [DW-1:0] m_dp;
   bit            m_dpv;
   bit            m_ov;
   smp_t          q[$];

   int            pulses = 0;
   logic [DW-1:0] trg_data = '0;
   int            n_out = 0;
   bit            last_xfer;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit stg_match(int k, logic [DW-1:0] d);
      logic [DW-1:0] msk, val, pos, neg;
      msk = cfg_msk[k*DW +: DW];
      val = cfg_val[k*DW +: DW];
      pos = cfg_pos[k*DW +: DW];
      neg = cfg_neg[k*DW +: DW];
      if (((d ^ val) & msk) != 0) return 1'b0;
      if ((pos | neg) == 0) return 1'b1;
      if (!m_dpv) return 1'b0;
      return ((d & ~m_dp & pos) | (~d & m_dp & neg)) != 0;
   endfunction

   function automatic int need(int k);
      int c;
      c = int'(cfg_cnt[k*CW +: CW]);
      return (c == 0) ? 1 : c;
   endfunction

   function automatic int last_stage();
      int n;
      n = int'(cfg_num);
      if (n == 0) n = 1;
      if (n > SN) n = SN;
      return n - 1;
   endfunction

   function automatic int sat(int v);
      return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
   endfunction

   task automatic model_clear();
      m_sta = 0;
      m_stg = 0;
      m_occ = 0;
      m_el  = 0;
      m_dp  = '0;
      m_dpv = 1'b0;
      m_ov  = 1'b0;
      q.delete();
   endtask

   // One clock: check handshakes, advance model, check registered outputs
   task automatic cycle();
      bit   rdy, xfer, fire, hit, tmo_on;
      smp_t s;
      #1;
      rdy = !m_ov || sto_tready;
      chk("sti_tready", sti_tready, rdy);
      xfer = sti_tvalid && rdy;
      last_xfer = xfer;
      if (sto_tvalid && sto_tready) begin
         n_out++;
         if (q.size() == 0) begin
            chk("out_unexpected", 1, 0);
         end else begin
            s = q.pop_front();
            chk("out_data", sto_tdata, s.d);
            chk("out_ttrg", sto_ttrg, s.t);
         end
      end
      fire = 1'b0;
      if (ctl_rst) begin
         model_clear();
      end else begin
         if (ctl_arm) begin
            m_sta = 1;
            m_stg = 0;
            m_occ = 0;
            m_el  = 0;
            m_dpv = 1'b0;
         end else if (m_sta == 2) begin
            m_sta = cfg_rpt ? 1 : 0;
            m_stg = 0;
            m_occ = 0;
            m_el  = 0;
         end else if (m_sta == 1) begin
            hit = xfer && stg_match(m_stg, sti_tdata);
            tmo_on = TMO_EN && m_stg > 0 && cfg_tmo != 0;
            if (!tmo_on) m_el = 0;
            if (hit) begin
               m_occ = sat(m_occ + 1);
               if (m_occ >= need(m_stg)) begin
                  m_occ = 0;
                  m_el  = 0;
                  if (m_stg >= last_stage()) begin
                     m_sta = 2;
                     fire  = 1'b1;
                  end else begin
                     m_stg++;
                  end
               end else if (tmo_on) begin
                  m_el = sat(m_el + 1);
               end
            end else if (tmo_on) begin
               m_el = sat(m_el + 1);
               if (m_el >= int'(cfg_tmo)) begin
                  m_stg = 0;
                  m_occ = 0;
                  m_el  = 0;
               end
            end
         end
         if (!ctl_arm && xfer) begin
            m_dp  = sti_tdata;
            m_dpv = 1'b1;
         end
         if (xfer) begin
            s.d = sti_tdata;
            s.t = fire;
            q.push_back(s);
            m_ov = 1'b1;
         end else if (sto_tready) begin
            m_ov = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("sts_sta", sts_sta, m_sta);
      chk("sts_stg", sts_stg, m_stg);
      chk("trg_out", trg_out, m_sta == 2);
      chk("sto_tvalid", sto_tvalid, m_ov);
      if (trg_out) begin
         pulses++;
         trg_data = sto_tdata;
      end
      @(negedge clk);
   endtask

   task automatic set_stage(int k, logic [DW-1:0] msk, logic [DW-1:0] val,
                            logic [DW-1:0] pos, logic [DW-1:0] neg,
                            logic [CW-1:0] cnt);
      cfg_msk[k*DW +: DW] = msk;
      cfg_val[k*DW +: DW] = val;
      cfg_pos[k*DW +: DW] = pos;
      cfg_neg[k*DW +: DW] = neg;
      cfg_cnt[k*CW +: CW] = cnt;
   endtask

   task automatic send(logic [DW-1:0] d);
      sti_tvalid = 1'b1;
      sti_tdata  = d;
      cycle();
      sti_tvalid = 1'b0;
   endtask

   task automatic idle(int n);
      sti_tvalid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic arm();
      sti_tvalid = 1'b0;
      ctl_arm = 1'b1;
      cycle();
      ctl_arm = 1'b0;
   endtask

   task automatic srst();
      sti_tvalid = 1'b0;
      ctl_rst = 1'b1;
      cycle();
      ctl_rst = 1'b0;
   endtask

   task automatic rnd_cfg();
      cfg_num = NW'($urandom_range(0, 3));
      cfg_rpt = 1'($urandom_range(0, 1));
      cfg_tmo = CW'($urandom_range(0, 6));
      for (int k = 0; k < SN; k++) begin
         set_stage(k, DW'($urandom_range(0, 7)), DW'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 7)) : '0,
                   ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 7)) : '0,
                   CW'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      int p0, n, r;
      rstn = 1'b0;
      ctl_rst = 1'b0;
      ctl_arm = 1'b0;
      cfg_num = '0;
      cfg_rpt = 1'b0;
      cfg_msk = '0;
      cfg_val = '0;
      cfg_pos = '0;
      cfg_neg = '0;
      cfg_cnt = '0;
      cfg_tmo = '0;
      sti_tdata = '0;
      sti_tvalid = 1'b0;
      sto_tready = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_sta", sts_sta, 0);
      chk("rst_stg", sts_stg, 0);
      chk("rst_tvalid", sto_tvalid, 0);
      chk("rst_ttrg", sto_ttrg, 0);
      chk("rst_tdata", sto_tdata, 0);
      chk("rst_trg", trg_out, 0);
      rstn = 1'b1;

      // Level stage then rising-edge stage
      cfg_num = 2;
      set_stage(0, 16'hFFFF, 16'h00FF, 16'h0, 16'h0, 1);
      set_stage(1, 16'h0000, 16'h0000, 16'h0001, 16'h0, 1);
      arm();
      p0 = pulses;
      send(16'h00FF);
      send(16'h0000);
      send(16'h0001);
      idle(2);
      chk("seq2_pulses", pulses - p0, 1);
      chk("seq2_data", trg_data, 16'h0001);
      chk("seq2_idle", sts_sta, 0);

      // Three occurrences required on a single stage
      srst();
      cfg_num = 1;
      set_stage(0, 16'hFF00, 16'hAB00, 16'h0, 16'h0, 3);
      arm();
      p0 = pulses;
      for (int i = 1; i <= 10; i++) begin
         if (i == 9) begin
            chk("occ_stg_pre", sts_stg, 0);
            chk("occ_sta_pre", sts_sta, 1);
         end
         send((i == 2 || i == 5 || i == 9) ? (16'hAB00 | 16'(i))
                                           : (16'h1100 | 16'(i)));
      end
      chk("occ_pulses", pulses - p0, 1);
      chk("occ_data", trg_data, 16'hAB09);

      // Inter-stage timeout of four cycles
      cfg_num = 2;
      cfg_tmo = 4;
      set_stage(0, 16'hFFFF, 16'h0011, 16'h0, 16'h0, 1);
      set_stage(1, 16'hFFFF, 16'h0022, 16'h0, 16'h0, 1);
      arm();
      send(16'h0011);
      chk("tmo_stg_in", sts_stg, 1);
      idle(4);
      chk("tmo_stg_out", sts_stg, TMO_EN ? 0 : 1);
      arm();
      send(16'h0011);
      idle(3);
      p0 = pulses;
      send(16'h0022);
      chk("tmo_fire", pulses - p0, 1);
      cfg_tmo = 0;
      idle(1);

      // Output backpressure with the trigger sample held in the register
      srst();
      cfg_num = 1;
      cfg_rpt = 1'b1;
      set_stage(0, 16'hFFFF, 16'h100E, 16'h0, 16'h0, 1);
      arm();
      p0 = pulses;
      n = 0;
      r = n_out;
      for (int i = 0; i < 50; i++) begin
         sto_tready = !(i >= 15 && i < 25);
         sti_tvalid = 1'b1;
         sti_tdata  = 16'h1000 + 16'(n);
         cycle();
         if (last_xfer) n++;
      end
      sti_tvalid = 1'b0;
      sto_tready = 1'b1;
      idle(3);
      chk("bp_pulses", pulses - p0, 1);
      chk("bp_count", n_out - r, n);

      // Repeat mode versus single shot
      cfg_num = 2;
      set_stage(0, 16'hFFFF, 16'h0A0A, 16'h0, 16'h0, 1);
      set_stage(1, 16'hFFFF, 16'h0B0B, 16'h0, 16'h0, 1);
      for (int m = 0; m < 2; m++) begin
         cfg_rpt = (m == 0);
         arm();
         p0 = pulses;
         repeat (3) begin
            send(16'h0A0A);
            send(16'h0B0B);
            send(16'h0000);
         end
         chk("rpt_pulses", pulses - p0, (m == 0) ? 3 : 1);
         chk("rpt_sta", sts_sta, (m == 0) ? 1 : 0);
      end

      // Asynchronous reset while armed in stage 1 with data held
      cfg_rpt = 1'b0;
      set_stage(0, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 1);
      set_stage(1, 16'hFFFF, 16'h0002, 16'h0, 16'h0, 1);
      arm();
      sto_tready = 1'b0;
      send(16'h0001);
      chk("ar_stg_pre", sts_stg, 1);
      chk("ar_tv_pre", sto_tvalid, 1);
      #2 rstn = 1'b0;
      #1;
      chk("ar_sta", sts_sta, 0);
      chk("ar_stg", sts_stg, 0);
      chk("ar_tvalid", sto_tvalid, 0);
      chk("ar_trg", trg_out, 0);
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      sto_tready = 1'b1;

      // Randomised configuration, traffic and control pulses
      for (int it = 0; it < 3000; it++) begin
         if (it % 300 == 0) rnd_cfg();
         r = $urandom_range(0, 99);
         ctl_rst = (r < 2);
         ctl_arm = (r >= 1 && r < 6);
         sti_tvalid = (r >= 6) && ($urandom_range(0, 3) != 0);
         sti_tdata  = DW'($urandom);
         sto_tready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      ctl_rst = 1'b0;
      ctl_arm = 1'b0;
      sto_tready = 1'b1;
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
